serial_sum_decoder: RTL and testbench

SERIAL_SUM_DECODER -- requirements
Module: serial_sum_decoder

---
 rtl/serial_sum_decoder.sv | 151 +++++++++++++++
 tb/tb_serial_sum_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sum_decoder.sv
// -----------------------------------------------------------------------------
// serial_sum_decoder
//
// Recovers the unknown addend a from an adder result word (sum = a + b, with
// bit WIDTH being the adder carry-out) and the known addend b. The subtraction
// is done serially. One DIGIT-bit slice is handled per clock, starting with
// the least-significant slice, so only a DIGIT-bit subtractor is built.
//
// Handshake: a valid/ready pair on each side. The control is a three-state
// FSM. IDLE accepts one operand pair. BUSY runs WIDTH/DIGIT slice steps. DONE
// holds the result until the consumer takes it.
//
// Parameters
//   WIDTH  operand width in bits (even, >= 4)
//   DIGIT  bits resolved per clock (must divide WIDTH)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_sum / in_b valid
//   in_ready   block can accept an operand pair (IDLE only)
//   in_sum     adder result word, bit WIDTH = carry-out
//   in_b       known addend
//   out_valid  out_a / out_err valid (DONE only)
//   out_ready  consumer accepts the result
//   out_a      recovered addend, (in_sum - in_b) mod 2^WIDTH
//   out_err    recovered addend does not fit in WIDTH bits
// -----------------------------------------------------------------------------
module serial_sum_decoder #(
  parameter int WIDTH = 12,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   in_sum,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic             out_err
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  // The operand registers shift right by one slice per step. The slice being
  // worked on therefore always sits in the low DIGIT bits.
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;

  logic [DIGIT:0]       w_diff;
  logic                 w_last;
  logic [WIDTH+DIGIT-1:0] w_res_cat;
  logic [WIDTH-1:0]     w_res_next;

  // Single DIGIT-bit slice subtractor. The extra top bit is the borrow-out:
  // the worst case 0 - (2^DIGIT-1) - 1 = -2^DIGIT still fits in DIGIT+1 bits.
  assign w_diff = {1'b0, r_sum[DIGIT-1:0]}
                - {1'b0, r_b[DIGIT-1:0]}
                - {{DIGIT{1'b0}}, r_borrow};

  // Result digits enter at the top and move down. After NSLICE steps the
  // first digit has reached bit 0.
  assign w_res_cat  = {w_diff[DIGIT-1:0], r_res};
  assign w_res_next = w_res_cat[WIDTH+DIGIT-1:DIGIT];

  assign w_last    = (r_cnt == LAST_SLICE);
  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);

  // NOTE: state is updated with non-blocking assignments only. Every register
  // then samples the values from before the edge, whatever the process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the next state is given a default before the case statement, so
  // every path assigns it and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = BUSY;
      BUSY:    if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum    <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      out_a    <= '0;
      out_err  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_sum    <= in_sum[WIDTH-1:0];
            r_carry  <= in_sum[WIDTH];
            r_b      <= in_b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        BUSY: begin
          r_sum    <= r_sum >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_res    <= w_res_next;
          r_borrow <= w_diff[DIGIT];
          r_cnt    <= r_cnt + CW'(1);
          // The outputs are loaded only on the step that enters DONE, so they
          // stay stable for the whole handshake and afterwards.
          if (w_last) begin
            out_a   <= w_res_next;
            // A carry-out cancelled by the final borrow means a valid result.
            // A leftover carry (result >= 2^WIDTH) or a leftover borrow
            // (negative result) means the addend does not fit.
            out_err <= r_carry ^ w_diff[DIGIT];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_sum_decoder.sv
// -----------------------------------------------------------------------------
// tb_serial_sum_decoder
//
// Directed and randomised self-checking bench for serial_sum_decoder with the
// default parameters (WIDTH=12, DIGIT=2). Inputs change 1 ns after a rising
// edge, and outputs are sampled at that same point.
// -----------------------------------------------------------------------------
module tb_serial_sum_decoder;

  localparam int WIDTH   = 12;
  localparam int LATENCY = 6;
  localparam int BOUND   = 20;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   in_sum;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_a;
  logic             out_err;

  int n_checks;
  int n_fail;

  serial_sum_decoder #(.WIDTH(WIDTH), .DIGIT(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step edges until out_valid rises, within a bound. Return the edge count.
  task automatic wait_result(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < BOUND) begin
      step();
      lat++;
    end
  endtask

  // Run a full transaction with out_ready held high. The input lines are
  // corrupted while BUSY/DONE, and in_valid stays high until after the
  // return edge, so a wrongly accepted pair on that edge would show up.
  task automatic run_op(input string tag, input logic [12:0] s, input logic [11:0] b,
                        input logic [11:0] exp_a, input logic exp_err);
    int lat;
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_sum    = s;
    in_b      = b;
    step();
    in_sum = ~s;
    in_b   = ~b;
    wait_result(lat);
    check({tag, " latency"}, 32'(lat), 32'(LATENCY));
    check({tag, " out_a"}, 32'(out_a), 32'(exp_a));
    check({tag, " out_err"}, 32'(out_err), 32'(exp_err));
    step();
    in_valid = 1'b0;
    check({tag, " back idle"}, 32'(in_ready), 32'd1);
    check({tag, " valid low"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    int accepted;
    int results;
    logic [11:0] ra;
    logic [11:0] rb;

    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    in_b      = '0;
    out_ready = 1'b1;

    #3;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_a", 32'(out_a), 32'd0);
    check("reset out_err", 32'(out_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Directed vectors.
    run_op("basic", 13'h0F00, 12'h0A5, 12'hE5B, 1'b0);
    run_op("carry cancel", 13'h1000, 12'h001, 12'hFFF, 1'b0);
    run_op("too large", 13'h1000, 12'h000, 12'h000, 1'b1);
    run_op("negative", 13'h0005, 12'h006, 12'hFFF, 1'b1);
    run_op("all ones", 13'h1FFE, 12'hFFF, 12'hFFF, 1'b0);
    run_op("zero", 13'h0000, 12'h000, 12'h000, 1'b0);

    // Hold in DONE with out_ready low for 10 cycles. The input lines are
    // wiggled meanwhile.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sum    = 13'h1ABC;
    in_b      = 12'h234;
    step();
    wait_result(lat);
    check("hold latency", 32'(lat), 32'(LATENCY));
    for (int i = 0; i < 10; i++) begin
      in_sum = 13'(i * 37);
      in_b   = 12'(i * 91);
      check("hold out_valid", 32'(out_valid), 32'd1);
      check("hold in_ready", 32'(in_ready), 32'd0);
      check("hold out_a", 32'(out_a), 32'h888);
      check("hold out_err", 32'(out_err), 32'd1);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("hold release idle", 32'(in_ready), 32'd1);
    check("hold release valid", 32'(out_valid), 32'd0);
    check("hold out_a after", 32'(out_a), 32'h888);

    // Reset in the middle of BUSY.
    in_valid = 1'b1;
    in_sum   = 13'h0F00;
    in_b     = 12'h0A5;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("mid reset in_ready", 32'(in_ready), 32'd1);
    check("mid reset out_valid", 32'(out_valid), 32'd0);
    check("mid reset out_a", 32'(out_a), 32'd0);
    check("mid reset out_err", 32'(out_err), 32'd0);
    repeat (2) step();
    check("in reset out_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b1;
    in_sum   = 13'h0123;
    in_b     = 12'h023;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    in_valid = 1'b0;
    check("post reset accepted", 32'(in_ready), 32'd0);
    wait_result(lat);
    check("post reset latency", 32'(lat), 32'(LATENCY));
    check("post reset out_a", 32'(out_a), 32'h100);
    check("post reset out_err", 32'(out_err), 32'd0);
    step();

    // Random pairs with random input gaps and consumer back-pressure.
    accepted = 0;
    results  = 0;
    for (int i = 0; i < 1000; i++) begin
      ra = 12'($urandom);
      rb = 12'($urandom);
      in_valid = 1'b0;
      out_ready = 1'b0;
      repeat ($urandom_range(0, 2)) step();
      check("rand in_ready", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_sum   = {1'b0, ra} + {1'b0, rb};
      in_b     = rb;
      step();
      accepted++;
      in_valid = 1'b0;
      lat = 0;
      while (lat < 4 * BOUND) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid === 1'b1 && out_ready === 1'b1) break;
        step();
        lat++;
      end
      check("rand done in time", 32'(out_valid & out_ready), 32'd1);
      if (out_valid === 1'b1) begin
        results++;
        check("rand out_a", 32'(out_a), 32'(ra));
        check("rand out_err", 32'(out_err), 32'd0);
      end
      step();
    end
    check("rand result count", 32'(results), 32'(accepted));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
